// File: rtl/conv2_sched_if.sv
// Window/result handshake bundle between conv2_sched and the
// shared dot-product unit plus downstream consumer.
interface conv2_sched_if;
   logic               win_valid;
   logic               win_ready;
   logic [1:0]         ch_sel;
   logic [3:0]         wbank;
   logic signed [19:0] dp_in;
   logic signed [13:0] conv_out;
   logic [1:0]         conv_oc;
   logic               conv_valid;
   logic               out_ready;
   logic               busy;

   modport master (
      input  win_valid,
      input  dp_in,
      input  out_ready,
      output win_ready,
      output ch_sel,
      output wbank,
      output conv_out,
      output conv_oc,
      output conv_valid,
      output busy
   );

   modport slave (
      output win_valid,
      output dp_in,
      output out_ready,
      input  win_ready,
      input  ch_sel,
      input  wbank,
      input  conv_out,
      input  conv_oc,
      input  conv_valid,
      input  busy
   );
endinterface

// File: rtl/conv2_sched.sv
// conv2_sched: time-multiplexes one 25-tap dot-product unit over
// 3 input channels x NUM_OC output channels per accepted window.
module conv2_sched #(
   parameter int NUM_OC = 3,
   parameter int SHIFT  = 6
) (
   input  logic          clk,
   input  logic          rst,
   conv2_sched_if.master sif
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } state_t;

   localparam logic [1:0] OC_LAST = 2'(NUM_OC - 1);

   state_t      state;
   logic [1:0]  oc;
   logic [1:0]  ic;
   logic [19:0] acc;
   logic [19:0] sum;

   assign sum = acc + sif.dp_in;

   assign sif.win_ready = (state == IDLE);
   assign sif.busy      = (state != IDLE);

   // Mux selects park at 0 when idle, hold last CALC values in OUT.
   assign sif.ch_sel = (state == IDLE) ? 2'd0 : ic;
   assign sif.wbank  = (state == IDLE) ? 4'd0
                     : ({2'b00, oc} * 4'd3) + {2'b00, ic};

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         oc             <= '0;
         ic             <= '0;
         acc            <= '0;
         sif.conv_out   <= '0;
         sif.conv_oc    <= '0;
         sif.conv_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (sif.win_valid) begin
                  state <= CALC;
                  oc    <= '0;
                  ic    <= '0;
                  acc   <= '0;
               end
            end
            CALC: begin
               acc <= sum;
               if (ic == 2'd2) begin
                  sif.conv_out   <= sum[SHIFT+13:SHIFT];
                  sif.conv_oc    <= oc;
                  sif.conv_valid <= 1'b1;
                  state          <= OUT;
               end else begin
                  ic <= ic + 2'd1;
               end
            end
            OUT: begin
               if (sif.out_ready) begin
                  sif.conv_valid <= 1'b0;
                  if (oc == OC_LAST) begin
                     state <= IDLE;
                  end else begin
                     oc    <= oc + 2'd1;
                     ic    <= '0;
                     acc   <= '0;
                     state <= CALC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
